// File: rtl/operand_loader_if.sv
// Operand-loader bus: switch/button inputs toward the loader and the captured
// operand pair, FSM state and load acknowledge back to the comparators/display.
interface operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             key_load_n;
    logic             key_clear_n;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic             valid;
    logic [1:0]       state_out;
    logic             load_ack;

    modport master (
        output sw, key_load_n, key_clear_n,
        input  x_out, y_out, valid, state_out, load_ack
    );

    modport slave (
        input  sw, key_load_n, key_clear_n,
        output x_out, y_out, valid, state_out, load_ack
    );
endinterface

// File: rtl/operand_loader.sv
// Captures two operands from board switches on debounced load presses and holds
// them, flagged valid, for the 4-bit comparators and the display.
module operand_loader #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input logic             clk,
    input logic             rst_n,
    operand_loader_if.slave bus
);
    localparam logic [1:0]       ST_WAIT_X = 2'b00;
    localparam logic [1:0]       ST_WAIT_Y = 2'b01;
    localparam logic [1:0]       ST_READY  = 2'b10;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam int               KEY_LOAD  = 0;
    localparam int               KEY_CLEAR = 1;

    // Per-key conditioning state; bit 0 is the load key, bit 1 the clear key.
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_db;
    logic [1:0]       r_db_d;
    logic [1:0]       r_arm;
    logic [1:0]       r_press;
    logic [1:0]       r_settle;
    logic [CNT_W-1:0] r_cnt [2];

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic [1:0]       r_state;
    logic             r_ack;

    logic [1:0]       w_press_edge;

    // A key is armed only after the synchronisers have flushed and a debounced
    // release has been seen, so a button held through reset gives no press.
    assign w_press_edge = r_db_d & ~r_db & r_arm;

    // Synchronise, debounce, edge-detect and register the press pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1     <= 2'b11;
            r_s2     <= 2'b11;
            r_db     <= 2'b11;
            r_db_d   <= 2'b11;
            r_arm    <= 2'b00;
            r_press  <= 2'b00;
            r_settle <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_s1    <= {bus.key_clear_n, bus.key_load_n};
            r_s2    <= r_s1;
            r_db_d  <= r_db;
            r_press <= w_press_edge;
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end else begin
                r_settle <= r_settle;
            end
            for (int k = 0; k < 2; k++) begin
                if (r_s2[k] != r_db[k]) begin
                    if (r_cnt[k] == DB_LAST) begin
                        r_db[k]  <= r_s2[k];
                        r_cnt[k] <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
                if ((r_settle == 2'd2) && r_s2[k] && r_db[k]) begin
                    r_arm[k] <= 1'b1;
                end
            end
        end
    end

    // Load FSM: clear has priority over load; READY + load starts a new pair
    // and drops valid in the same edge that x changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_state <= ST_WAIT_X;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (r_press[KEY_CLEAR]) begin
                r_x     <= '0;
                r_y     <= '0;
                r_valid <= 1'b0;
                r_state <= ST_WAIT_X;
            end else begin
                case (r_state)
                    ST_WAIT_X: begin
                        if (r_press[KEY_LOAD]) begin
                            r_x     <= bus.sw;
                            r_state <= ST_WAIT_Y;
                            r_ack   <= 1'b1;
                        end
                    end
                    ST_WAIT_Y: begin
                        if (r_press[KEY_LOAD]) begin
                            r_y     <= bus.sw;
                            r_valid <= 1'b1;
                            r_state <= ST_READY;
                            r_ack   <= 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (r_press[KEY_LOAD]) begin
                            r_x     <= bus.sw;
                            r_valid <= 1'b0;
                            r_state <= ST_WAIT_Y;
                            r_ack   <= 1'b1;
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= ST_WAIT_X;
                    end
                endcase
            end
        end
    end

    assign bus.x_out     = r_x;
    assign bus.y_out     = r_y;
    assign bus.valid     = r_valid;
    assign bus.state_out = r_state;
    assign bus.load_ack  = r_ack;
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader with a short debounce window.
module tb_operand_loader;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       v;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   acks = 0;
    exp_t sb_q[$];

    operand_loader_if #(.WIDTH(4)) bus ();

    operand_loader #(.WIDTH(4), .DB_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every load_ack must match the next expected capture.
    always @(negedge clk) begin
        if (rst_n && bus.load_ack) begin
            exp_t e;
            acks++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack expected none (x=%0h)", bus.x_out);
            end else begin
                e = sb_q.pop_front();
                chk("ack_x", 32'(bus.x_out), 32'(e.x));
                chk("ack_y", 32'(bus.y_out), 32'(e.y));
                chk("ack_valid", 32'(bus.valid), 32'(e.v));
                chk("ack_state", 32'(bus.state_out), 32'(e.st));
            end
        end
    end

    task automatic press(input logic use_load, input logic use_clear);
        @(negedge clk);
        bus.key_load_n  = ~use_load;
        bus.key_clear_n = ~use_clear;
        repeat (8) @(negedge clk);
        bus.key_load_n  = 1'b1;
        bus.key_clear_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.sw          = 4'h0;
        bus.key_load_n  = 1'b1;
        bus.key_clear_n = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(bus.x_out), 32'h0);
        chk("rst_y", 32'(bus.y_out), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_state", 32'(bus.state_out), 32'h0);
        chk("rst_ack", 32'(bus.load_ack), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Test 1: first press captures x with fixed latency
        bus.sw = 4'h3;
        bus.key_load_n = 1'b0;
        sb_q.push_back('{x: 4'h3, y: 4'h0, v: 1'b0, st: 2'b01});
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 6) chk("lat_x_before", 32'(bus.x_out), 32'h0);
            if (e == 7) begin
                chk("lat_x_at7", 32'(bus.x_out), 32'h3);
                chk("lat_ack_at7", 32'(bus.load_ack), 32'h1);
            end
            if (e == 8) chk("lat_ack_at8", 32'(bus.load_ack), 32'h0);
        end
        @(negedge clk);
        bus.key_load_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t1_state", 32'(bus.state_out), 32'h1);
        chk("t1_valid", 32'(bus.valid), 32'h0);

        // Test 2: second press captures y, pair valid
        bus.sw = 4'h9;
        sb_q.push_back('{x: 4'h3, y: 4'h9, v: 1'b1, st: 2'b10});
        press(1'b1, 1'b0);
        chk("t2_state", 32'(bus.state_out), 32'h2);
        chk("t2_valid", 32'(bus.valid), 32'h1);
        chk("t2_x_lt_y", 32'(bus.x_out < bus.y_out), 32'h1);

        // Test 3: bounces shorter than the window are ignored
        n = acks;
        bus.sw = 4'h5;
        @(negedge clk);
        bus.key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.key_load_n = 1'b1;
        @(negedge clk);
        bus.key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.key_load_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t3_no_ack", 32'(acks), 32'(n));
        chk("t3_state", 32'(bus.state_out), 32'h2);
        chk("t3_x_held", 32'(bus.x_out), 32'h3);

        // Test 4: READY + load starts a new pair, y held, valid dropped
        bus.sw = 4'hF;
        sb_q.push_back('{x: 4'hF, y: 4'h9, v: 1'b0, st: 2'b01});
        press(1'b1, 1'b0);
        chk("t4_state", 32'(bus.state_out), 32'h1);
        chk("t4_y", 32'(bus.y_out), 32'h9);

        // Test 5: load and clear together, clear wins with no ack
        n = acks;
        bus.sw = 4'hA;
        press(1'b1, 1'b1);
        chk("t5_no_ack", 32'(acks), 32'(n));
        chk("t5_state", 32'(bus.state_out), 32'h0);
        chk("t5_x", 32'(bus.x_out), 32'h0);
        chk("t5_y", 32'(bus.y_out), 32'h0);
        chk("t5_valid", 32'(bus.valid), 32'h0);
        bus.sw = 4'h7;
        repeat (5) @(negedge clk);
        chk("t5_sw_idle", 32'(bus.x_out), 32'h0);

        // Test 6: reset mid-debounce with the key held
        bus.sw = 4'h5;
        sb_q.push_back('{x: 4'h5, y: 4'h0, v: 1'b0, st: 2'b01});
        press(1'b1, 1'b0);
        chk("t6_pre_x", 32'(bus.x_out), 32'h5);
        n = acks;
        bus.key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_x", 32'(bus.x_out), 32'h0);
        chk("t6_rst_state", 32'(bus.state_out), 32'h0);
        chk("t6_rst_ack", 32'(bus.load_ack), 32'h0);
        repeat (20) @(negedge clk);
        chk("t6_held_no_ack", 32'(acks), 32'(n));
        chk("t6_held_x", 32'(bus.x_out), 32'h0);
        bus.key_load_n = 1'b1;
        repeat (12) @(negedge clk);
        bus.sw = 4'h6;
        sb_q.push_back('{x: 4'h6, y: 4'h0, v: 1'b0, st: 2'b01});
        press(1'b1, 1'b0);
        chk("t6_repress_acks", 32'(acks), 32'(n + 1));

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
